// File: rtl/trade_z_engine.sv
// Multi-cycle Z-score trade engine: iterative sqrt of (sq_mean - mean^2), restoring
// divide of |price-mean| by stddev, then buy/sell decisions with per-direction cooldown.
module trade_z_engine #(
  parameter int DATA_W   = 16,
  parameter int INT_BITS = 10,
  parameter int Z_FRAC   = 8,
  parameter int Z_THRESH = 512,
  parameter int COOLDOWN = 4,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [DATA_W-1:0]   mean,
  input  logic [2*DATA_W-1:0] sq_mean,
  input  logic [DATA_W-1:0]   price,
  output logic                out_valid,
  output logic [TAG_W-1:0]    out_tag,
  output logic                buy_signal,
  output logic                sell_signal,
  output logic                suppressed,
  output logic                zero_var,
  output logic [2*DATA_W-1:0] z_score,
  output logic [DATA_W-1:0]   stddev
);
  localparam int W2    = 2 * DATA_W;
  localparam int DW    = DATA_W + Z_FRAC;
  localparam int CNT_W = $clog2(DW + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int RS_W  = DATA_W + 3;
  localparam int RD_W  = DATA_W + 1;

  if (INT_BITS < 0 || INT_BITS > DATA_W) begin : g_bad_int_bits
    $error("INT_BITS must lie within DATA_W");
  end

  typedef enum logic [1:0] {IDLE, SQRT, DIV, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [W2-1:0]     var_sh;
  logic [RS_W-1:0]   rs;
  logic [DATA_W-1:0] root;
  logic [DW-1:0]     quo;
  logic [RD_W-1:0]   rd;
  logic              zv;
  logic              is_buy;
  logic              is_sell;
  logic [TAG_W-1:0]  tag_q;
  logic [CD_W-1:0]   cd_buy;
  logic [CD_W-1:0]   cd_sell;

  assign in_ready = (state == IDLE) && !rst;

  // Capture-time arithmetic; variance clamps to zero when sq_mean < mean^2.
  logic [W2-1:0]     mean_sq;
  logic [W2-1:0]     var_in;
  logic [DATA_W-1:0] delta_in;
  assign mean_sq  = W2'(mean) * W2'(mean);
  assign var_in   = (sq_mean >= mean_sq) ? sq_mean - mean_sq : '0;
  assign delta_in = (price >= mean) ? price - mean : mean - price;

  // One square-root bit per cycle: bring down two radicand bits, try (root<<2)|1.
  logic [RS_W-1:0]   rs_sh;
  logic [RS_W-1:0]   rs_trial;
  logic              rs_ge;
  logic [DATA_W-1:0] root_nxt;
  assign rs_sh    = (rs << 2) | RS_W'(var_sh[W2-1 -: 2]);
  assign rs_trial = RS_W'({root, 2'b01});
  assign rs_ge    = rs_sh >= rs_trial;
  assign root_nxt = (root << 1) | DATA_W'(rs_ge);

  // One quotient bit per cycle; quotient bits shift into the dividend register.
  logic [RD_W-1:0] rd_sh;
  logic            rd_ge;
  assign rd_sh = (rd << 1) | RD_W'(quo[DW-1]);
  assign rd_ge = rd_sh >= RD_W'(root);

  logic [W2-1:0] z_val;
  logic          qual;
  logic          fire_buy;
  logic          fire_sell;
  logic          blocked;
  assign z_val     = zv ? '0 : W2'(quo);
  assign qual      = z_val > W2'(Z_THRESH);
  assign fire_buy  = qual && is_buy  && (cd_buy  == '0);
  assign fire_sell = qual && is_sell && (cd_sell == '0);
  assign blocked   = qual && ((is_buy && cd_buy != '0) || (is_sell && cd_sell != '0));

  function automatic logic [CD_W-1:0] cd_next(input logic [CD_W-1:0] c, input logic fire);
    if (fire) return CD_W'(COOLDOWN);
    return (c != '0) ? c - 1'b1 : '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      var_sh      <= '0;
      rs          <= '0;
      root        <= '0;
      quo         <= '0;
      rd          <= '0;
      zv          <= 1'b0;
      is_buy      <= 1'b0;
      is_sell     <= 1'b0;
      tag_q       <= '0;
      cd_buy      <= '0;
      cd_sell     <= '0;
      out_valid   <= 1'b0;
      out_tag     <= '0;
      buy_signal  <= 1'b0;
      sell_signal <= 1'b0;
      suppressed  <= 1'b0;
      zero_var    <= 1'b0;
      z_score     <= '0;
      stddev      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= SQRT;
            cnt     <= '0;
            tag_q   <= in_tag;
            var_sh  <= var_in;
            rs      <= '0;
            root    <= '0;
            rd      <= '0;
            quo     <= DW'(delta_in) << Z_FRAC;
            is_buy  <= price < mean;
            is_sell <= price > mean;
          end
        end
        SQRT: begin
          var_sh <= var_sh << 2;
          rs     <= rs_ge ? rs_sh - rs_trial : rs_sh;
          root   <= root_nxt;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= DIV;
            cnt   <= '0;
            zv    <= (root_nxt == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          // A zero divisor still runs the full count so latency never varies.
          rd  <= rd_ge ? rd_sh - RD_W'(root) : rd_sh;
          quo <= (quo << 1) | DW'(rd_ge);
          if (cnt == CNT_W'(DW - 1)) state <= DONE;
          else                       cnt   <= cnt + 1'b1;
        end
        DONE: begin
          out_valid   <= 1'b1;
          out_tag     <= tag_q;
          buy_signal  <= fire_buy;
          sell_signal <= fire_sell;
          suppressed  <= blocked;
          zero_var    <= zv;
          z_score     <= z_val;
          stddev      <= root;
          cd_buy      <= cd_next(cd_buy, fire_buy);
          cd_sell     <= cd_next(cd_sell, fire_sell);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trade_z_engine.sv
// Bench for trade_z_engine: directed scenarios plus randomized handshake traffic,
// all compared against an arithmetic reference model of the Z-score rules.
module tb_trade_z_engine;
  localparam int DATA_W   = 16;
  localparam int Z_FRAC   = 8;
  localparam int TAG_W    = 4;
  localparam int Z_THRESH = 512;
  localparam int CD       = 2;
  localparam int LAT      = 2 * DATA_W + Z_FRAC + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [TAG_W-1:0]    in_tag = '0;
  logic [DATA_W-1:0]   mean = '0;
  logic [2*DATA_W-1:0] sq_mean = '0;
  logic [DATA_W-1:0]   price = '0;
  logic                out_valid;
  logic [TAG_W-1:0]    out_tag;
  logic                buy_signal;
  logic                sell_signal;
  logic                suppressed;
  logic                zero_var;
  logic [2*DATA_W-1:0] z_score;
  logic [DATA_W-1:0]   stddev;

  trade_z_engine #(.DATA_W(DATA_W), .INT_BITS(10), .Z_FRAC(Z_FRAC), .Z_THRESH(Z_THRESH),
                   .COOLDOWN(CD), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .mean(mean), .sq_mean(sq_mean), .price(price), .out_valid(out_valid),
    .out_tag(out_tag), .buy_signal(buy_signal), .sell_signal(sell_signal),
    .suppressed(suppressed), .zero_var(zero_var), .z_score(z_score), .stddev(stddev));

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]    tag;
    logic [DATA_W-1:0]   mn;
    logic [2*DATA_W-1:0] sq;
    logic [DATA_W-1:0]   pr;
  } smp_t;

  typedef struct {
    bit     buy, sell, sup, zv;
    longint z, sd;
  } res_t;

  int checks = 0;
  int failures = 0;
  int m_cd_buy = 0;
  int m_cd_sell = 0;

  task automatic check(input string nm, input string fld, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", nm, fld, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else                hi = mid - 1;
    end
    return lo;
  endfunction

  // Reference: real-number rules done in wide integers, cooldown as two plain counters.
  task automatic model(input smp_t s, output res_t r);
    longint mn, sq, pr, v, d;
    bit q;
    mn = longint'(s.mn);
    sq = longint'(s.sq);
    pr = longint'(s.pr);
    v  = (sq >= mn * mn) ? sq - mn * mn : 0;
    d  = (pr > mn) ? pr - mn : mn - pr;
    r.sd = isqrt(v);
    r.zv = (r.sd == 0);
    r.z  = r.zv ? 0 : (d * (longint'(1) << Z_FRAC)) / r.sd;
    q = (r.z > Z_THRESH) && (pr != mn);
    r.buy  = q && (pr < mn) && (m_cd_buy == 0);
    r.sell = q && (pr > mn) && (m_cd_sell == 0);
    r.sup  = q && !r.buy && !r.sell;
    m_cd_buy  = r.buy  ? CD : (m_cd_buy  > 0 ? m_cd_buy  - 1 : 0);
    m_cd_sell = r.sell ? CD : (m_cd_sell > 0 ? m_cd_sell - 1 : 0);
  endtask

  function automatic smp_t mk(input int tg, input int mn, input longint sq, input int pr);
    smp_t s;
    s.tag = TAG_W'(tg);
    s.mn  = DATA_W'(mn);
    s.sq  = (2*DATA_W)'(sq);
    s.pr  = DATA_W'(pr);
    return s;
  endfunction

  task automatic rnd(output smp_t s);
    longint mm, v;
    int off;
    s.tag = TAG_W'($urandom);
    s.mn  = DATA_W'($urandom_range(60000, 1000));
    mm = longint'(s.mn) * longint'(s.mn);
    case ($urandom_range(3, 0))
      0:       v = longint'($urandom_range(4000, 0));
      1:       v = longint'($urandom_range(1 << 20, 0));
      2:       v = 0;
      default: v = -longint'($urandom_range(1000, 0));
    endcase
    s.sq = (2*DATA_W)'(mm + v);
    off  = int'($urandom_range(1200, 0)) - 600;
    s.pr = DATA_W'(int'(s.mn) + off);
  endtask

  task automatic drive(input smp_t s);
    in_tag  = s.tag;
    mean    = s.mn;
    sq_mean = s.sq;
    price   = s.pr;
  endtask

  task automatic check_res(input string nm, input smp_t s, output res_t r);
    model(s, r);
    check(nm, "tag",  64'(out_tag),     64'(s.tag));
    check(nm, "buy",  64'(buy_signal),  64'(r.buy));
    check(nm, "sell", 64'(sell_signal), 64'(r.sell));
    check(nm, "sup",  64'(suppressed),  64'(r.sup));
    check(nm, "zvar", 64'(zero_var),    64'(r.zv));
    check(nm, "z",    64'(z_score),     64'(r.z));
    check(nm, "sd",   64'(stddev),      64'(r.sd));
  endtask

  // One sample, in_valid dropped after accept; checks latency, busy window and results.
  task automatic run_one(input string nm, input smp_t s);
    int n, w;
    bit seen, busy_ok;
    res_t r;
    smp_t junk;
    @(negedge clk);
    in_valid = 1'b1;
    drive(s);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check(nm, "ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rnd(junk);
    drive(junk);
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < LAT + 10 && !seen; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else if (in_ready) busy_ok = 1'b0;
    end
    check(nm, "valid", 64'(seen), 64'(1));
    check(nm, "latency", 64'(n), 64'(LAT));
    check(nm, "busy", 64'(busy_ok), 64'(1));
    check(nm, "ready_at_done", 64'(in_ready), 64'(1));
    check_res(nm, s, r);
    @(negedge clk);
    check(nm, "pulse", 64'(out_valid), 64'(0));
    check(nm, "hold_z", 64'(z_score), 64'(r.z));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  localparam longint SQ4 = 40976384;
  localparam bit EXP_BUY [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit EXP_SUP [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    smp_t s, hs;
    smp_t q[$];
    res_t r;
    int last_acc, res_cnt;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst", "in_ready", 64'(in_ready), 64'(0));
    check("rst", "out_valid", 64'(out_valid), 64'(0));
    check("rst", "flags", 64'({buy_signal, sell_signal, suppressed, zero_var}), 64'(0));
    check("rst", "z", 64'(z_score), 64'(0));
    check("rst", "sd", 64'(stddev), 64'(0));
    check("rst", "tag", 64'(out_tag), 64'(0));
    rst = 1'b0;
    #1;
    check("rst", "ready_after", 64'(in_ready), 64'(1));

    // Directed decisions
    run_one("buy", mk(3, 6400, SQ4, 6080));
    check("buy", "buy_c", 64'(buy_signal), 64'(1));
    check("buy", "z_c", 64'(z_score), 64'(640));
    check("buy", "sd_c", 64'(stddev), 64'(128));
    run_one("sell", mk(5, 6400, SQ4, 6720));
    check("sell", "sell_c", 64'(sell_signal), 64'(1));
    check("sell", "z_c", 64'(z_score), 64'(640));
    run_one("small", mk(6, 6400, SQ4, 6464));
    check("small", "z_c", 64'(z_score), 64'(128));
    check("small", "sig_c", 64'({buy_signal, sell_signal}), 64'(0));
    run_one("flat", mk(7, 6400, SQ4, 6400));
    check("flat", "z_c", 64'(z_score), 64'(0));
    run_one("zvar", mk(8, 6400, 40960000, 6080));
    check("zvar", "zv_c", 64'(zero_var), 64'(1));
    check("zvar", "sd_c", 64'(stddev), 64'(0));
    run_one("negvar", mk(9, 6400, 40000000, 6720));
    check("negvar", "zv_c", 64'(zero_var), 64'(1));
    check("negvar", "sig_c", 64'({buy_signal, sell_signal}), 64'(0));

    // Cooldown: five buys, then an interleaved sell
    for (int i = 0; i < 5; i++) begin
      run_one($sformatf("cd%0d", i), mk(10 + i, 6400, SQ4, 6080));
      check($sformatf("cd%0d", i), "buy_c", 64'(buy_signal), 64'(EXP_BUY[i]));
      check($sformatf("cd%0d", i), "sup_c", 64'(suppressed), 64'(EXP_SUP[i]));
    end
    run_one("cdsell", mk(15, 6400, SQ4, 6720));
    check("cdsell", "sell_c", 64'(sell_signal), 64'(1));

    // Handshake: in_valid held high with fresh random data every cycle
    last_acc = -1;
    res_cnt = 0;
    for (int c = 0; c < 12 * (LAT + 1) && res_cnt < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("hs", "pending", 64'(q.size()), 64'(1));
        if (q.size() > 0) begin
          hs = q.pop_front();
          check_res("hs", hs, r);
        end
        res_cnt++;
      end
      rnd(s);
      in_valid = 1'b1;
      drive(s);
      if (in_ready) begin
        q.push_back(s);
        if (last_acc >= 0) check("hs", "spacing", 64'(c - last_acc), 64'(LAT + 1));
        last_acc = c;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < LAT + 10 && q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        hs = q.pop_front();
        check_res("hs_tail", hs, r);
        res_cnt++;
      end
    end
    check("hs", "drained", 64'(q.size()), 64'(0));
    check("hs", "results", 64'(res_cnt), 64'(11));

    // Reset mid-operation with a loaded buy cooldown
    run_one("drain0", mk(1, 6400, SQ4, 6400));
    run_one("drain1", mk(2, 6400, SQ4, 6400));
    run_one("prebuy", mk(4, 6400, SQ4, 6080));
    check("prebuy", "buy_c", 64'(buy_signal), 64'(1));
    @(negedge clk);
    in_valid = 1'b1;
    drive(mk(12, 6400, SQ4, 6080));
    check("mid", "ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid", "in_ready", 64'(in_ready), 64'(0));
    check("mid", "out_valid", 64'(out_valid), 64'(0));
    check("mid", "z", 64'(z_score), 64'(0));
    check("mid", "sd", 64'(stddev), 64'(0));
    check("mid", "flags", 64'({buy_signal, sell_signal, suppressed, zero_var}), 64'(0));
    check("mid", "tag", 64'(out_tag), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    m_cd_buy = 0;
    m_cd_sell = 0;
    #1;
    check("mid", "ready_after", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid", "no_result", 64'(seen), 64'(0));
    run_one("postrst", mk(13, 6400, SQ4, 6080));
    check("postrst", "buy_c", 64'(buy_signal), 64'(1));
    check("postrst", "sup_c", 64'(suppressed), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
